// File: rtl/fft_pkg.sv
// Shared definitions for the FFT frame sequencer: default widths,
// complex word layout and sequencer state encoding.
package fft_pkg;

  localparam int FFT_N_LOG2 = 6;
  localparam int FFT_DW     = 16;

  typedef struct packed {
    logic signed [FFT_DW-1:0] re;
    logic signed [FFT_DW-1:0] im;
  } cplx_t;

  typedef enum logic [2:0] {
    FILL,
    LOAD,
    START,
    WAIT,
    DRAIN
  } seq_state_t;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Load/start/done handshake between the frame sequencer and the FFT core.
interface fft_frame_sequencer_if
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW     = FFT_DW
) ();

  logic              fft_load;
  logic              fft_start;
  logic [N_LOG2-1:0] fft_adr;
  logic [2*DW-1:0]   fft_rd;
  logic              fft_done;
  logic [2*DW-1:0]   fft_wd;

  modport master (
    output fft_load, fft_start, fft_adr, fft_rd,
    input  fft_done, fft_wd
  );

  modport slave (
    input  fft_load, fft_start, fft_adr, fft_rd,
    output fft_done, fft_wd
  );

endinterface

// File: rtl/fft_frame_buffer.sv
// Circular sample history: N x DW simple dual-port RAM, one write port and
// a registered read port (no read reset, so it maps onto a block RAM).
module fft_frame_buffer
  import fft_pkg::*;
#(
  parameter int AW = FFT_N_LOG2,
  parameter int DW = FFT_DW
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // Synchronous write and registered read
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Frames a real sample stream into overlapping N-point frames, loads them
// into the FFT core, and streams the returned bins with |X|^2.
module fft_frame_sequencer
  import fft_pkg::*;
#(
  parameter int N_LOG2 = FFT_N_LOG2,
  parameter int DW     = FFT_DW,
  parameter int HOP    = 32
) (
  input  logic                 slow_clk,
  input  logic                 reset,
  input  logic                 sample_valid,
  input  logic signed [DW-1:0] sample_in,
  output logic                 sample_ready,
  output logic                 overrun,
  fft_frame_sequencer_if.master core,
  output logic                 bin_valid,
  output logic [N_LOG2-1:0]    bin_idx,
  output logic signed [DW-1:0] bin_re,
  output logic signed [DW-1:0] bin_im,
  output logic [2*DW:0]        bin_mag,
  output logic                 bin_last
);

  localparam logic [N_LOG2:0] N_CNT   = (N_LOG2+1)'(1 << N_LOG2);
  localparam logic [N_LOG2:0] HOP_CNT = (N_LOG2+1)'(HOP);

  seq_state_t          state;
  logic [N_LOG2-1:0]   wptr, wptr_nxt, frz, rd_addr, adr_q, bin_k;
  logic [N_LOG2:0]     fill_cnt, fill_nxt, hop_cnt, hop_nxt;
  logic                accept, frame_ready, load_q, start_q, last_q;
  logic [DW-1:0]       rd_data;
  logic signed [DW-1:0]   wd_re, wd_im;
  logic signed [2*DW-1:0] re_sq, im_sq;
  logic [2*DW:0]       mag_nxt;

  fft_frame_buffer #(.AW(N_LOG2), .DW(DW)) u_buf (
    .clk   (slow_clk),
    .we    (accept),
    .waddr (wptr),
    .wdata (sample_in),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // Next counter values and the one-cycle-early buffer read address
  always_comb begin
    accept   = sample_valid & sample_ready;
    wptr_nxt = wptr;
    fill_nxt = fill_cnt;
    hop_nxt  = hop_cnt;
    if (accept) begin
      wptr_nxt = wptr + 1'b1;
      if (fill_cnt != N_CNT) fill_nxt = fill_cnt + 1'b1;
      if (hop_cnt != N_CNT)  hop_nxt  = hop_cnt + 1'b1;
    end
    frame_ready = (fill_nxt == N_CNT) && (hop_nxt >= HOP_CNT);
    rd_addr     = (state == LOAD) ? frz + adr_q + 1'b1 : wptr_nxt;
  end

  // Magnitude squared of the incoming core word at full width
  always_comb begin
    wd_re   = core.fft_wd[2*DW-1:DW];
    wd_im   = core.fft_wd[DW-1:0];
    re_sq   = (2*DW)'(wd_re) * (2*DW)'(wd_re);
    im_sq   = (2*DW)'(wd_im) * (2*DW)'(wd_im);
    mag_nxt = {1'b0, re_sq} + {1'b0, im_sq};
  end

  // Sequencer FSM, counters and registered outputs
  always_ff @(posedge slow_clk) begin
    if (!reset) begin
      state        <= FILL;
      wptr         <= '0;
      fill_cnt     <= '0;
      hop_cnt      <= '0;
      frz          <= '0;
      adr_q        <= '0;
      bin_k        <= '0;
      load_q       <= 1'b0;
      start_q      <= 1'b0;
      last_q       <= 1'b0;
      sample_ready <= 1'b1;
      overrun      <= 1'b0;
      bin_valid    <= 1'b0;
      bin_idx      <= '0;
      bin_re       <= '0;
      bin_im       <= '0;
      bin_mag      <= '0;
    end else begin
      bin_valid <= 1'b0;
      last_q    <= 1'b0;
      start_q   <= 1'b0;
      if (sample_valid && !sample_ready) overrun <= 1'b1;
      wptr     <= wptr_nxt;
      fill_cnt <= fill_nxt;
      hop_cnt  <= hop_nxt;
      unique case (state)
        FILL: begin
          if (frame_ready) begin
            state        <= LOAD;
            hop_cnt      <= '0;
            frz          <= wptr_nxt;
            adr_q        <= '0;
            load_q       <= 1'b1;
            sample_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (&adr_q) begin
            state        <= START;
            adr_q        <= '0;
            load_q       <= 1'b0;
            start_q      <= 1'b1;
            sample_ready <= 1'b1;
          end else begin
            adr_q <= adr_q + 1'b1;
          end
        end
        START: state <= WAIT;
        WAIT: begin
          if (core.fft_done) begin
            bin_valid <= 1'b1;
            bin_idx   <= '0;
            bin_re    <= wd_re;
            bin_im    <= wd_im;
            bin_mag   <= mag_nxt;
            bin_k     <= {{(N_LOG2-1){1'b0}}, 1'b1};
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          if (core.fft_done) begin
            bin_valid <= 1'b1;
            bin_idx   <= bin_k;
            bin_re    <= wd_re;
            bin_im    <= wd_im;
            bin_mag   <= mag_nxt;
            bin_k     <= bin_k + 1'b1;
            if (&bin_k) begin
              last_q <= 1'b1;
              state  <= FILL;
            end
          end else begin
            state <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  // An early done drop is only seen while the previous bin is already on the
  // outputs, so that bin is flagged last combinationally from fft_done.
  assign bin_last = last_q | (bin_valid && (state == DRAIN) && !core.fft_done);

  assign core.fft_load  = load_q;
  assign core.fft_start = start_q;
  assign core.fft_adr   = adr_q;
  assign core.fft_rd    = load_q ? {rd_data, {DW{1'b0}}} : '0;

endmodule
